// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline-stage registers.
package pipe_pkg;

   // Stage occupancy. The encoding doubles as the occ count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } stage_state_t;

   // Register-file control bundle layout.
   localparam int unsigned RF_WE_W       = 1;
   localparam int unsigned RF_WADDR_W    = 5;
   localparam int unsigned RF_MUX_W      = 3;
   localparam int unsigned RF_WE_BIT     = 0;
   localparam int unsigned RF_WADDR_LSB  = RF_WE_BIT + RF_WE_W;
   localparam int unsigned RF_MUX_LSB    = RF_WADDR_LSB + RF_WADDR_W;
   localparam int unsigned RF_CTRL_W     = RF_MUX_LSB + RF_MUX_W;

   // Default widths per stage boundary.
   localparam int unsigned IF_ID_DATA_W  = 64;
   localparam int unsigned ID_EX_DATA_W  = 128;
   localparam int unsigned EX_MEM_DATA_W = 128;
   localparam int unsigned MEM_WB_DATA_W = 128;
   localparam int unsigned DATA_W_DEF    = MEM_WB_DATA_W;
   localparam int unsigned CTRL_W_DEF    = RF_CTRL_W;
   localparam int unsigned CNT_W_DEF     = 16;

   // Extract the RF write enable from a control bundle.
   function automatic logic ctrl_rf_we(input logic [RF_CTRL_W-1:0] ctrl);
      return ctrl[RF_WE_BIT];
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins).
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: clear, else increment unless already at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with main+skid entries, flush and stall counter.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned CTRL_W = CTRL_W_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occ,
   input  logic              clr_cnt,
   output logic [CNT_W-1:0]  stall_cnt
);

   stage_state_t      state_q, state_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic              in_fire, out_fire;

   // Handshake outputs come from the state register only.
   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign occ       = 2'(state_q);
   assign out_data  = main_data_q;
   assign out_ctrl  = out_valid ? main_ctrl_q : '0;

   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   // Next-state and entry updates; flush empties the stage and zeroes ctrl.
   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      unique case (state_q)
         EMPTY: begin
            if (in_fire) begin
               main_data_d = in_data;
               main_ctrl_d = in_ctrl;
               state_d     = ONE;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               main_data_d = in_data;
               main_ctrl_d = in_ctrl;
            end else if (in_fire) begin
               skid_data_d = in_data;
               skid_ctrl_d = in_ctrl;
               state_d     = FULL;
            end else if (out_fire) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (out_fire) begin
               main_data_d = skid_data_q;
               main_ctrl_d = skid_ctrl_q;
               state_d     = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (flush) begin
         state_d     = EMPTY;
         main_data_d = main_data_q;
         skid_data_d = skid_data_q;
         main_ctrl_d = '0;
         skid_ctrl_d = '0;
      end
   end

   // State and entry registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= EMPTY;
         main_data_q <= '0;
         main_ctrl_q <= '0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (out_valid & ~out_ready),
      .clr_i (clr_cnt),
      .cnt_o (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomized self-checking bench for pipe_stage_skid against a queue model.
module tb_pipe_stage_skid;

   localparam int unsigned DW = 128;
   localparam int unsigned CW = 9;

   logic          clk, rst, flush, in_valid, out_ready, clr_cnt;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;

   logic          in_ready, out_valid;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
   logic [1:0]    occ;
   logic [15:0]   stall_cnt;

   logic          in_ready4, out_valid4;
   logic [DW-1:0] out_data4;
   logic [CW-1:0] out_ctrl4;
   logic [1:0]    occ4;
   logic [3:0]    stall_cnt4;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   typedef struct {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } beat_t;

   beat_t       mq[$];
   int unsigned sc16, sc4;

   pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_ctrl(out_ctrl), .occ(occ), .clr_cnt(clr_cnt),
      .stall_cnt(stall_cnt)
   );

   pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
      .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid4), .out_ready(out_ready),
      .out_data(out_data4), .out_ctrl(out_ctrl4), .occ(occ4), .clr_cnt(clr_cnt),
      .stall_cnt(stall_cnt4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic check_reset_values();
      check_eq("rst_out_valid", DW'(out_valid), '0);
      check_eq("rst_in_ready", DW'(in_ready), DW'(1));
      check_eq("rst_occ", DW'(occ), '0);
      check_eq("rst_out_ctrl", DW'(out_ctrl), '0);
      check_eq("rst_out_data", out_data, '0);
      check_eq("rst_stall_cnt", DW'(stall_cnt), '0);
      check_eq("rst_stall_cnt4", DW'(stall_cnt4), '0);
   endtask

   // One clock cycle: drive inputs, compare outputs with the model, advance both.
   task automatic step(input logic iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic ordy, input logic fl, input logic clr, output logic acc);
      int unsigned n;
      logic        ofire;
      beat_t       b;
      in_valid  = iv;
      in_ctrl   = c;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      clr_cnt   = clr;
      n = mq.size();
      check_eq("out_valid", DW'(out_valid), DW'(n > 0));
      check_eq("in_ready", DW'(in_ready), DW'(n < 2));
      check_eq("occ", DW'(occ), DW'(n));
      check_eq("out_valid4", DW'(out_valid4), DW'(n > 0));
      check_eq("in_ready4", DW'(in_ready4), DW'(n < 2));
      check_eq("occ4", DW'(occ4), DW'(n));
      if (n > 0) begin
         check_eq("out_ctrl", DW'(out_ctrl), DW'(mq[0].c));
         check_eq("out_data", out_data, mq[0].d);
         check_eq("out_data4", out_data4, mq[0].d);
      end else begin
         check_eq("out_ctrl_idle", DW'(out_ctrl), '0);
      end
      check_eq("out_ctrl4", DW'(out_ctrl4), DW'(out_ctrl));
      check_eq("stall_cnt", DW'(stall_cnt), DW'(sc16));
      check_eq("stall_cnt4", DW'(stall_cnt4), DW'(sc4));
      acc   = iv && (n < 2);
      ofire = (n > 0) && ordy;
      if (clr) begin
         sc16 = 0;
         sc4  = 0;
      end else if ((n > 0) && !ordy) begin
         if (sc16 < 65535) sc16++;
         if (sc4 < 15) sc4++;
      end
      if (fl) begin
         mq.delete();
      end else begin
         if (ofire) void'(mq.pop_front());
         if (acc) begin
            b.c = c;
            b.d = d;
            mq.push_back(b);
         end
      end
      @(posedge clk);
      #1;
   endtask

   logic          acc;
   int unsigned   beat;
   logic [DW-1:0] pat;

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
      in_data = '0; in_ctrl = '0;
      sc16 = 0; sc4 = 0;
      #12 rst = 1'b0;
      @(posedge clk);
      #1;
      check_reset_values();

      // First beat after reset, then stream 1..10 at full rate.
      pat = {32{4'hA}};
      step(1'b1, 9'h1FF, pat, 1'b1, 1'b0, 1'b0, acc);
      for (int i = 1; i <= 10; i++) begin
         step(1'b1, 9'(i), DW'(i), 1'b1, 1'b0, 1'b0, acc);
      end
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);

      // Back-pressure: beats 1,2,3 offered while downstream stalls, then drain.
      beat = 1;
      for (int i = 0; i < 6; i++) begin
         step(beat <= 3, 9'(beat), DW'(beat), 1'b0, 1'b0, 1'b0, acc);
         if (acc) beat++;
      end
      for (int i = 0; i < 6; i++) begin
         step(beat <= 3, 9'(beat), DW'(beat), 1'b1, 1'b0, 1'b0, acc);
         if (acc) beat++;
      end

      // Fill, then flush with a beat arriving on the same edge.
      step(1'b1, 9'h0F1, DW'(32'hF1), 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 9'h0F2, DW'(32'hF2), 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 9'h0F3, DW'(32'hF3), 1'b0, 1'b1, 1'b0, acc);
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);

      // Long stall saturates the narrow counter, then clear while still stalled.
      step(1'b1, 9'h055, DW'(32'h55), 1'b0, 1'b0, 1'b0, acc);
      for (int i = 0; i < 20; i++) begin
         step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
      end
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         pat = {$urandom, $urandom, $urandom, $urandom};
         step(1'($urandom_range(0, 3) != 0), 9'($urandom), pat,
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0),
              1'($urandom_range(0, 39) == 0), acc);
      end

      // Asynchronous reset between edges while FULL.
      step(1'b1, 9'h1AA, DW'(32'hAA), 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 9'h1BB, DW'(32'hBB), 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 9'h1CC, DW'(32'hCC), 1'b0, 1'b0, 1'b0, acc);
      check_eq("full_before_rst", DW'(occ), DW'(2));
      #2 rst = 1'b1;
      #1;
      check_reset_values();
      mq.delete();
      sc16 = 0;
      sc4  = 0;
      #1 rst = 1'b0;
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);
      step(1'b1, 9'h011, DW'(32'h11), 1'b1, 1'b0, 1'b0, acc);
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
